// File: rtl/dfu_sys_feeder.sv
// Feeds matrices A and B into the systolic array with a per-row/per-column diagonal skew.
// After the last beat it waits out a drain window, then pulses done.
module dfu_sys_feeder #(
  parameter int ROW   = 8,
  parameter int COL   = 8,
  parameter int K     = 8,
  parameter int ES    = 8,
  parameter int DRAIN = 16,
  localparam int MX   = (ROW > COL) ? ROW : COL,
  localparam int IW   = (MX > 1) ? $clog2(MX) : 1,
  localparam int KW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [IW-1:0]     wr_i,
  input  logic [KW-1:0]     wr_k,
  input  logic [ES-1:0]     wr_data,
  output logic              wr_err,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROW-1:0]    dfu2sys_a_data_in_vld,
  output logic [ROW*ES-1:0] dfu2sys_a_data_in,
  output logic [COL-1:0]    dfu2sys_b_data_in_vld,
  output logic [COL*ES-1:0] dfu2sys_b_data_in
);

  localparam int S  = K + MX - 1;
  localparam int TW = (S > 1) ? $clog2(S) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam int AW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] t, t_nx;
  logic [DW-1:0] d, d_nx;

  // b_mem is stored column-major: b_mem[c][k] holds B[k][c]
  logic [ES-1:0] a_mem [ROW][K];
  logic [ES-1:0] b_mem [COL][K];

  logic              wr_ok;
  logic              load;
  logic [TW-1:0]     beat;
  logic [ROW-1:0]    a_vld_nx;
  logic [ROW*ES-1:0] a_data_nx;
  logic [COL-1:0]    b_vld_nx;
  logic [COL*ES-1:0] b_data_nx;

  logic              wr_err_p0;
  logic [ROW-1:0]    a_vld_p0;
  logic [ROW*ES-1:0] a_data_p0;
  logic [COL-1:0]    b_vld_p0;
  logic [COL*ES-1:0] b_data_p0;

  assign wr_ok = wr_en && (state == ST_IDLE) && (int'(wr_k) < K) &&
                 (wr_sel ? (int'(wr_i) < COL) : (int'(wr_i) < ROW));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (!wr_sel) a_mem[wr_i[AW-1:0]][wr_k] <= wr_data;
      else         b_mem[wr_i[CW-1:0]][wr_k] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      t     <= '0;
      d     <= '0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      d     <= d_nx;
    end
  end

  always_comb begin
    state_nx = state;
    t_nx     = t;
    d_nx     = d;
    case (state)
      ST_IDLE: if (start) begin
        state_nx = ST_STREAM;
        t_nx     = '0;
      end
      ST_STREAM: if (t == TW'(S - 1)) begin
        state_nx = ST_DRAIN;
        d_nx     = '0;
      end else begin
        t_nx = t + TW'(1);
      end
      ST_DRAIN: if (d == DW'(DRAIN - 1)) state_nx = ST_IDLE;
                else d_nx = d + DW'(1);
      default: state_nx = ST_IDLE;
    endcase
  end

  // The output register holds the beat t currently counted, so the next beat is computed one ahead.
  assign load = ((state == ST_IDLE) && start) || ((state == ST_STREAM) && (t != TW'(S - 1)));
  assign beat = (state == ST_IDLE) ? '0 : t + TW'(1);

  // A write coinciding with start is forwarded so the first beats see the new element.
  always_comb begin
    a_vld_nx  = '0;
    a_data_nx = '0;
    b_vld_nx  = '0;
    b_data_nx = '0;
    for (int r = 0; r < ROW; r++) begin
      if (load && (int'(beat) >= r) && (int'(beat) - r < K)) begin
        a_vld_nx[r] = 1'b1;
        if (wr_ok && !wr_sel && int'(wr_i) == r && int'(wr_k) == int'(beat) - r)
          a_data_nx[r*ES +: ES] = wr_data;
        else
          a_data_nx[r*ES +: ES] = a_mem[r][KW'(int'(beat) - r)];
      end
    end
    for (int c = 0; c < COL; c++) begin
      if (load && (int'(beat) >= c) && (int'(beat) - c < K)) begin
        b_vld_nx[c] = 1'b1;
        if (wr_ok && wr_sel && int'(wr_i) == c && int'(wr_k) == int'(beat) - c)
          b_data_nx[c*ES +: ES] = wr_data;
        else
          b_data_nx[c*ES +: ES] = b_mem[c][KW'(int'(beat) - c)];
      end
    end
  end

  // Stage p0: registered stream beat and write-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_p0 <= 1'b0;
      a_vld_p0  <= '0;
      a_data_p0 <= '0;
      b_vld_p0  <= '0;
      b_data_p0 <= '0;
    end else begin
      wr_err_p0 <= wr_en && !wr_ok;
      a_vld_p0  <= a_vld_nx;
      a_data_p0 <= a_data_nx;
      b_vld_p0  <= b_vld_nx;
      b_data_p0 <= b_data_nx;
    end
  end

  assign wr_err                = wr_err_p0;
  assign busy                  = (state != ST_IDLE);
  assign done                  = (state == ST_DRAIN) && (d == DW'(DRAIN - 1));
  assign dfu2sys_a_data_in_vld = a_vld_p0;
  assign dfu2sys_a_data_in     = a_data_p0;
  assign dfu2sys_b_data_in_vld = b_vld_p0;
  assign dfu2sys_b_data_in     = b_data_p0;

endmodule

// File: tb/tb_dfu_sys_feeder.sv
// Directed bench for dfu_sys_feeder: 4x4x4 matrices, drain window of 4 cycles.
module tb_dfu_sys_feeder;
  localparam int ROW = 4, COL = 4, K = 4, ES = 8, DRAIN = 4;
  localparam int S = K + ROW - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, wr_sel = 1'b0;
  logic [1:0] wr_i = '0, wr_k = '0;
  logic [7:0] wr_data = '0;
  logic start = 1'b0, start2 = 1'b0;
  logic wr_err, busy, done;
  logic [3:0] a_vld, b_vld;
  logic [31:0] a_data, b_data;

  logic wr_err2, busy2, done2;
  logic [2:0] a_vld2;
  logic [23:0] a_data2;
  logic [3:0] b_vld2;
  logic [31:0] b_data2;

  int total = 0;
  int passed = 0;
  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  always #5 clk = ~clk;

  dfu_sys_feeder #(.ROW(ROW), .COL(COL), .K(K), .ES(ES), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_i(wr_i), .wr_k(wr_k),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .busy(busy), .done(done),
    .dfu2sys_a_data_in_vld(a_vld), .dfu2sys_a_data_in(a_data),
    .dfu2sys_b_data_in_vld(b_vld), .dfu2sys_b_data_in(b_data));

  // Narrower A side so an out-of-range A row index is representable on wr_i.
  dfu_sys_feeder #(.ROW(3), .COL(4), .K(K), .ES(ES), .DRAIN(DRAIN)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_i(wr_i), .wr_k(wr_k),
    .wr_data(wr_data), .wr_err(wr_err2), .start(start2), .busy(busy2), .done(done2),
    .dfu2sys_a_data_in_vld(a_vld2), .dfu2sys_a_data_in(a_data2),
    .dfu2sys_b_data_in_vld(b_vld2), .dfu2sys_b_data_in(b_data2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] i, input logic [1:0] k, input logic [7:0] v);
    wr_en = 1'b1; wr_sel = sel; wr_i = i; wr_k = k; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [3:0] exp_avld(input int t);
    exp_avld = '0;
    for (int r = 0; r < 4; r++) if (t - r >= 0 && t - r < K) exp_avld[r] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_adata(input int t);
    exp_adata = '0;
    for (int r = 0; r < 4; r++) if (t - r >= 0 && t - r < K) exp_adata[r*8 +: 8] = ma[r][t-r];
  endfunction

  function automatic logic [31:0] exp_bdata(input int t);
    exp_bdata = '0;
    for (int c = 0; c < 4; c++) if (t - c >= 0 && t - c < K) exp_bdata[c*8 +: 8] = mb[t-c][c];
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_avld"}, 64'(a_vld), 64'h0);
    chk({tag, "_bvld"}, 64'(b_vld), 64'h0);
    chk({tag, "_adata"}, 64'(a_data), 64'h0);
    chk({tag, "_bdata"}, 64'(b_data), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_done"}, 64'(done), 64'h0);
  endtask

  // Starts in the current (idle) cycle; returns positioned in the done cycle.
  task automatic run_stream(input string tag, input bit poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= S + DRAIN; c++) begin
      chk({tag, "_avld"}, 64'(a_vld), 64'(exp_avld(c - 1)));
      chk({tag, "_adata"}, 64'(a_data), 64'(exp_adata(c - 1)));
      chk({tag, "_bvld"}, 64'(b_vld), 64'(exp_avld(c - 1)));
      chk({tag, "_bdata"}, 64'(b_data), 64'(exp_bdata(c - 1)));
      chk({tag, "_busy"}, 64'(busy), 64'h1);
      chk({tag, "_done"}, 64'(done), 64'(c == S + DRAIN));
      start = poke && (c == 3 || c == 5);
      if (c < S + DRAIN) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    // 1: reset values, and start held under reset stays idle
    tick();
    tick();
    check_idle("rst");
    chk("rst_wrerr", 64'(wr_err), 64'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("rst_start");
    rst = 1'b0;
    tick();

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        ma[r][k] = 8'(16 * r + k);
        mb[k][r] = 8'(16 * k + r);
        wr(1'b0, 2'(r), 2'(k), ma[r][k]);
        wr(1'b1, 2'(r), 2'(k), mb[k][r]);
      end
    chk("load_wrerr", 64'(wr_err), 64'h0);
    tick();

    // 2: skew with hand-computed values, start in cycle 0
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_busy", 64'(busy), 64'h1);
    chk("c1_avld", 64'(a_vld), 64'h1);
    chk("c1_adata", 64'(a_data), 64'h0);
    chk("c1_bvld", 64'(b_vld), 64'h1);
    tick(); tick(); tick();
    chk("c4_avld", 64'(a_vld), 64'hf);
    chk("c4_adata", 64'(a_data), 64'h30211203);
    chk("c4_bvld", 64'(b_vld), 64'hf);
    chk("c4_bdata", 64'(b_data), 64'h03122130);
    tick(); tick(); tick();
    chk("c7_avld", 64'(a_vld), 64'h8);
    chk("c7_adata", 64'(a_data), 64'h33000000);
    chk("c7_bvld", 64'(b_vld), 64'h8);
    chk("c7_bdata", 64'(b_data), 64'h33000000);
    tick();
    chk("c8_avld", 64'(a_vld), 64'h0);
    tick(); tick();
    chk("c10_done", 64'(done), 64'h0);
    tick();
    chk("c11_done", 64'(done), 64'h1);
    chk("c11_busy", 64'(busy), 64'h1);
    tick();
    check_idle("c12");

    // 3: start pokes during the stream are ignored
    run_stream("poke", 1'b1);
    tick();
    check_idle("poke_after");

    // 4: write while busy and out-of-range A row are both dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    wr(1'b0, 2'd0, 2'd0, 8'hff);
    chk("busy_wrerr", 64'(wr_err), 64'h1);
    for (int c = 0; c < S + DRAIN; c++) tick();
    chk("busy_wrerr_idle", 64'(busy), 64'h0);
    wr(1'b0, 2'd3, 2'd0, ma[3][0]);
    chk("range_wrerr", 64'(wr_err2), 64'h1);
    chk("range_ok_main", 64'(wr_err), 64'h0);
    wr(1'b1, 2'd3, 2'd0, mb[0][3]);
    chk("range_b_ok", 64'(wr_err2), 64'h0);
    run_stream("recheck", 1'b0);
    tick();

    // 5: reset in the middle of the stream
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_avld_t3", 64'(a_vld), 64'hf);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort");
    for (int c = 0; c < S + DRAIN; c++) begin
      chk("abort_nodone", 64'(done), 64'h0);
      tick();
    end
    run_stream("replay", 1'b0);
    tick();

    // 6: write coinciding with start, then back-to-back streams
    ma[0][0] = 8'h5a;
    wr_en = 1'b1; wr_sel = 1'b0; wr_i = 2'd0; wr_k = 2'd0; wr_data = 8'h5a;
    run_stream("wrstart", 1'b0);
    tick();
    run_stream("b2b", 1'b0);
    tick();
    check_idle("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
